// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen size, circle FSM states, octant index and
// the signed datapath widths used by the midpoint circle engine.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        PLOT   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } circle_state_t;

    typedef logic [2:0] octant_t;

    // Coordinates can go negative or past the screen edge before clipping.
    typedef logic signed [9:0]  coord_t;
    typedef logic signed [10:0] crit_t;

    // True when a computed pixel lies on the visible 160x120 screen.
    function automatic logic in_screen(coord_t x, coord_t y);
        return !x[9] && (x < coord_t'(SCREEN_W)) &&
               !y[9] && (y < coord_t'(SCREEN_H));
    endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Combinational octant mapper: turns centre + (ox, oy) + octant index into a
// screen pixel and its plot enable. Clipping to the screen is compiled in
// with CIRCLE_CLIP_EN; otherwise every pixel is plotted and coordinates wrap.
module circle_octant_map
    import vga_pkg::*;
(
    input  logic [7:0] cx_i,
    input  logic [6:0] cy_i,
    input  coord_t     ox_i,
    input  coord_t     oy_i,
    input  octant_t    oct_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       plot_o
);

    coord_t cx_s, cy_s, px, py;

    // Octant order fixes the pixel sequence seen on the VGA write port.
    always_comb begin
        cx_s = {2'b00, cx_i};
        cy_s = {3'b000, cy_i};
        px   = cx_s;
        py   = cy_s;
        case (oct_i)
            3'd0: begin px = cx_s + ox_i; py = cy_s + oy_i; end
            3'd1: begin px = cx_s + oy_i; py = cy_s + ox_i; end
            3'd2: begin px = cx_s - ox_i; py = cy_s + oy_i; end
            3'd3: begin px = cx_s - oy_i; py = cy_s + ox_i; end
            3'd4: begin px = cx_s - ox_i; py = cy_s - oy_i; end
            3'd5: begin px = cx_s - oy_i; py = cy_s - ox_i; end
            3'd6: begin px = cx_s + ox_i; py = cy_s - oy_i; end
            default: begin px = cx_s + oy_i; py = cy_s - ox_i; end
        endcase
        x_o = px[7:0];
        y_o = py[6:0];
`ifdef CIRCLE_CLIP_EN
        plot_o = in_screen(px, py);
`else
        plot_o = 1'b1;
`endif
    end

endmodule

// File: rtl/circle.sv
// Midpoint circle drawer for a 160x120 VGA adapter. One pixel per PLOT
// cycle, eight octants per iteration, all outputs registered.
// Optional screen clipping: define CIRCLE_CLIP_EN.
module circle
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic       start,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    circle_state_t state_q;
    octant_t       oct_q;
    coord_t        ox_q, oy_q;
    crit_t         crit_q;
    logic [7:0]    cx_q, rad_q;
    logic [6:0]    cy_q;
    logic [2:0]    col_q;
    logic          done_q, plot_q;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [2:0]    vcol_q;

    // Next-iteration values and octant mapper operands
    coord_t  ox_d, oy_d, ox_init, diff;
    crit_t   crit_d, crit_init;
    logic    more_d, load_px;
    coord_t  map_ox, map_oy;
    octant_t map_oct;
    logic [7:0] map_x;
    logic [6:0] map_y;
    logic       map_plot;

    // Midpoint step, and selection of the pixel that the next edge loads.
    always_comb begin
        ox_init   = {2'b00, rad_q};
        crit_init = crit_t'(1) - crit_t'({3'b000, rad_q});
        oy_d      = oy_q + coord_t'(1);
        ox_d      = ox_q;
        diff      = '0;
        if (crit_q[10] || (crit_q == '0)) begin
            crit_d = crit_q + crit_t'({oy_d, 1'b1});
        end else begin
            ox_d   = ox_q - coord_t'(1);
            diff   = oy_d - ox_d;
            crit_d = crit_q + crit_t'({diff, 1'b1});
        end
        more_d = (oy_d <= ox_d);

        map_ox  = ox_q;
        map_oy  = oy_q;
        map_oct = octant_t'(oct_q + 3'd1);
        case (state_q)
            INIT:    begin map_ox = ox_init; map_oy = '0;   map_oct = '0; end
            UPDATE:  begin map_ox = ox_d;    map_oy = oy_d; map_oct = '0; end
            default: ;
        endcase

        load_px = start && ((state_q == INIT) ||
                            ((state_q == PLOT) && (oct_q != 3'd7)) ||
                            ((state_q == UPDATE) && more_d));
    end

    circle_octant_map u_map (
        .cx_i   (cx_q),
        .cy_i   (cy_q),
        .ox_i   (map_ox),
        .oy_i   (map_oy),
        .oct_i  (map_oct),
        .x_o    (map_x),
        .y_o    (map_y),
        .plot_o (map_plot)
    );

    // Control FSM with the iteration state and registered VGA outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            oct_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            crit_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            rad_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            vcol_q  <= '0;
        end else begin
            done_q <= 1'b0;
            plot_q <= load_px ? map_plot : 1'b0;
            if (load_px) begin
                x_q    <= map_x;
                y_q    <= map_y;
                vcol_q <= col_q;
            end
            case (state_q)
                IDLE: if (start) begin
                    cx_q    <= centre_x;
                    cy_q    <= centre_y;
                    rad_q   <= radius;
                    col_q   <= colour;
                    state_q <= INIT;
                end
                INIT: if (!start) state_q <= IDLE;
                else begin
                    ox_q    <= ox_init;
                    oy_q    <= '0;
                    crit_q  <= crit_init;
                    oct_q   <= '0;
                    state_q <= PLOT;
                end
                PLOT: if (!start) state_q <= IDLE;
                else if (oct_q == 3'd7) state_q <= UPDATE;
                else oct_q <= octant_t'(oct_q + 3'd1);
                UPDATE: if (!start) state_q <= IDLE;
                else begin
                    ox_q   <= ox_d;
                    oy_q   <= oy_d;
                    crit_q <= crit_d;
                    oct_q  <= '0;
                    if (more_d) state_q <= PLOT;
                    else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: if (start) done_q <= 1'b1;
                else state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = vcol_q;

endmodule

// File: doc/circle.md
CIRCLE -- requirements
Module: circle

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port colour, input, 3 bits: pixel colour, passed unmodified to vga_colour.
REQ-004 SHALL have ports centre_x (8 bits) and centre_y (7 bits), inputs: circle centre in 160x120 screen coordinates.
REQ-005 SHALL have port radius, input, 8 bits: circle radius in pixels, unsigned.
REQ-006 SHALL have port start, input, 1 bit: level request; held high for the whole draw.
REQ-007 SHALL have port done, output, 1 bit: draw complete.
REQ-008 SHALL have ports vga_x (8 bits), vga_y (7 bits), vga_colour (3 bits) and vga_plot (1 bit), outputs: pixel-write interface for the vga_adapter.

Function
REQ-009 SHALL latch colour, centre_x, centre_y and radius on the IDLE->INIT transition; later input changes SHALL NOT affect the draw in progress.
REQ-010 SHALL implement states IDLE, INIT, PLOT, UPDATE and DONE.
- IDLE->INIT when start=1.
- INIT->PLOT after 1 cycle.
- PLOT runs 8 cycles, octant 0..7, then goes to UPDATE.
- UPDATE->PLOT if oy<=ox, else DONE.
REQ-011 SHALL, in INIT, set ox=radius, oy=0 and crit=1-radius, using signed arithmetic of at least 10 bits for coordinates and 11 bits for crit.
REQ-012 SHALL, in PLOT, emit one pixel per cycle in this order:
- 0: (cx+ox, cy+oy)
- 1: (cx+oy, cy+ox)
- 2: (cx-ox, cy+oy)
- 3: (cx-oy, cy+ox)
- 4: (cx-ox, cy-oy)
- 5: (cx-oy, cy-ox)
- 6: (cx+ox, cy-oy)
- 7: (cx+oy, cy-ox)
REQ-013 SHALL, in UPDATE, perform oy+=1 and then:
- if crit<=0: crit+=2*oy+1;
- else: ox-=1 and crit+=2*(oy-ox)+1;
- in both cases using the updated oy and ox.
REQ-014 SHALL drive vga_plot=0 in IDLE, INIT, UPDATE and DONE.
REQ-015 SHALL drive vga_plot=1 in PLOT only when 0<=x<160 and 0<=y<120 (subject to REQ-022); duplicate pixels on axes and diagonals SHALL be plotted again, not suppressed.
REQ-016 SHALL hold done=1 in DONE while start=1; start=0 in DONE SHALL return the block to IDLE with done=0 on the next cycle.
REQ-017 SHALL abort to IDLE on the next edge if start drops in INIT, PLOT or UPDATE; done SHALL remain 0.
REQ-018 SHALL, with radius=0, perform one iteration that plots (cx,cy) eight times, then reach DONE.

Reset
REQ-019 SHALL, while rst_n=0 and regardless of clk, force state=IDLE and done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-020 SHALL discard any draw in progress on reset; the first cycle after release SHALL be IDLE.

Configuration
REQ-021 SHALL support macro CIRCLE_CLIP_EN.
REQ-022 SHALL, with CIRCLE_CLIP_EN defined, apply the REQ-015 bounds check.
- Without it: vga_plot=1 for every PLOT cycle.
- Without it: vga_x and vga_y are the low 8 and 7 bits of the computed coordinate (wrap-around).

Structure
REQ-023 SHALL take SCREEN_W=160, SCREEN_H=120, the state enum typedef and the 3-bit octant typedef from shared package vga_pkg.
REQ-024 SHALL place the combinational octant-to-coordinate mapping and clip check in sub-module circle_octant_map; circle keeps the FSM and registers.

Verification
REQ-025 SHALL verify: centre (80,60), radius 0, start held
- -> 8 plots, all at (80,60).
- -> done=1 after the 11th rising edge following the first edge that samples start=1.
REQ-026 SHALL verify: centre (80,60), radius 1
- -> 16 plots in total.
- -> first octet: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
- -> second octet: the four corners (81,61),(79,61),(79,59),(81,59), each plotted twice.
- -> then done.
REQ-027 SHALL verify: centre (0,0), radius 10 with CIRCLE_CLIP_EN
- -> octant 0 of iteration 0 plots (10,0).
- -> octant 2 of iteration 0 has vga_plot=0.
- -> no plotted x>=160 or y>=120.
REQ-028 SHALL verify: start dropped after the 5th PLOT cycle -> IDLE the next cycle, vga_plot=0, done never asserted.
REQ-029 SHALL verify: rst_n pulsed low mid-PLOT, between clock edges -> outputs zero immediately; a new start redraws from INIT.
REQ-030 SHALL verify: centre (80,60), radius 40, compared against a software midpoint model -> identical pixel sequence, then done=1 held until start=0.
